io_responder: RTL and testbench
===============================

IO_RESPONDER -- requirements
Module: io_responder

Interface
REQ-001 Parameter WIDTH, default 16, data word width of CPU bus and device side.
REQ-002 Parameter DEPTH, default 4, TX FIFO entries; power of two, at least 2.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 we  input  1  CPU store strobe, one cycle per access.
REQ-006 re  input  1  CPU load strobe; pop side effect occurs on the clock edge.
REQ-007 addr  input  2  register select: 0 TXDATA, 1 RXDATA, 2 STATUS, 3 IRQMASK.
REQ-008 wdata  input  WIDTH  store data.
REQ-009 rdata  output  WIDTH  combinational load data for addr.
REQ-010 out_valid  output  1  TX FIFO head valid toward device.
REQ-011 out_data  output  WIDTH  TX FIFO head word.
REQ-012 out_ready  input  1  device accepts head.
REQ-013 in_valid  input  1  device offers a word.
REQ-014 in_data  input  WIDTH  device word.
REQ-015 in_ready  output  1  RX holding register empty.
REQ-016 irq  output  1  level interrupt request to CPU.

Function
REQ-017 Store to addr 0 with TX FIFO not full shall push wdata at the clock edge; no CPU stall exists.
REQ-018 Store to addr 0 with FIFO full at that edge shall drop the word and set sticky tx_ovf, even if a device pop occurs in the same cycle.
REQ-019 out_valid shall equal FIFO not empty; out_data shall be the head word, stable while out_valid and not out_ready.
REQ-020 Pop on out_valid and out_ready at the clock edge; simultaneous push (not full) and pop keeps count unchanged.
REQ-021 Pointers wrap modulo DEPTH; count ranges 0..DEPTH, with clog2(DEPTH)+1 bits.
REQ-022 in_ready shall equal not rx_full; in_valid and in_ready shall capture in_data and set rx_full at the edge.
REQ-023 Load addr 1 shall return the RX register; re to addr 1 with rx_full shall clear rx_full at the edge; with rx empty, load returns 0 and no state changes.
REQ-024 STATUS bits: [0] tx_empty, [1] tx_full, [2] rx_full, [3] tx_ovf, [7:4] count, others 0.
REQ-025 Store to addr 2 with wdata[3]=1 shall clear tx_ovf; other bits are read-only.
REQ-026 Store to addr 1 and load of addr 0 shall have no effect; load addr 0 returns 0.
REQ-027 we and re together on the same addr shall both take effect.

Reset
REQ-028 Reset shall empty the FIFO and set tx_ovf=0, rx_full=0, IRQMASK=0, out_valid=0, in_ready=1, irq=0, independent of clk.
REQ-029 Reset mid-transfer shall discard all buffered words; FIFO storage need not be cleared.

Configuration
REQ-030 With IO_RESPONDER_IRQ_EN defined, IRQMASK[2:0] shall be read/write and irq = (mask[0]&tx_empty)|(mask[1]&rx_full)|(mask[2]&tx_ovf), registered with one cycle latency.
REQ-031 Without IO_RESPONDER_IRQ_EN, irq shall be tied 0, stores to addr 3 shall be ignored, and loads of addr 3 shall return 0.

Structure
REQ-032 A shared package shall hold the addr encodings and STATUS bit positions.
REQ-033 The FIFO shall be a sub-module io_fifo (WIDTH, DEPTH) with push, pop, full, empty and count outputs.

Verification
REQ-034 After reset, STATUS reads 0x0001, in_ready=1, out_valid=0 and irq=0.
REQ-035 Store 0x1234, 0x5678 with out_ready=0 gives count 2; raising out_ready yields 0x1234 then 0x5678, ending with tx_empty=1.
REQ-036 Five stores with DEPTH=4 and out_ready=0 leave the first four words queued, set tx_ovf, and read STATUS 0x004A; storing 0x0008 to addr 2 clears tx_ovf.
REQ-037 in_valid with 0xBEEF sets rx_full and drops in_ready; a second in_valid is held off; load addr 1 returns 0xBEEF and in_ready rises the next cycle.
REQ-038 With IO_RESPONDER_IRQ_EN, store mask 0x2, then RX capture makes irq=1 one cycle later; the RX pop makes irq=0 one cycle later.
REQ-039 Asserting reset while count=3 with out_valid=1 drops out_valid immediately, and STATUS reads 0x0001.

Source files
------------

// File: rtl/io_responder_pkg.sv
// Shared register map for the io_responder CPU-facing register block:
// address encodings, STATUS bit positions and the STATUS packing helper.
package io_responder_pkg;

    typedef enum logic [1:0] {
        ADDR_TXDATA  = 2'd0,
        ADDR_RXDATA  = 2'd1,
        ADDR_STATUS  = 2'd2,
        ADDR_IRQMASK = 2'd3
    } addr_e;

    localparam int ST_TX_EMPTY  = 0;
    localparam int ST_TX_FULL   = 1;
    localparam int ST_RX_FULL   = 2;
    localparam int ST_TX_OVF    = 3;
    localparam int ST_COUNT_LSB = 4;
    localparam int ST_COUNT_W   = 4;
    localparam int ST_W         = 8;

    function automatic logic [ST_W-1:0] pack_status(
        input logic                  tx_empty,
        input logic                  tx_full,
        input logic                  rx_full,
        input logic                  tx_ovf,
        input logic [ST_COUNT_W-1:0] count
    );
        logic [ST_W-1:0] s;
        s                               = '0;
        s[ST_TX_EMPTY]                  = tx_empty;
        s[ST_TX_FULL]                   = tx_full;
        s[ST_RX_FULL]                   = rx_full;
        s[ST_TX_OVF]                    = tx_ovf;
        s[ST_COUNT_LSB +: ST_COUNT_W]   = count;
        return s;
    endfunction

endpackage

// File: rtl/io_responder_if.sv
// CPU register bus plus device-side TX/RX handshakes of io_responder.
// The responder block uses the slave modport; the CPU/device side the master.
interface io_responder_if #(
    parameter int WIDTH = 16
);
    logic             we;
    logic             re;
    logic [1:0]       addr;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] rdata;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             irq;

    modport master (
        output we, re, addr, wdata, out_ready, in_valid, in_data,
        input  rdata, out_valid, out_data, in_ready, irq
    );

    modport slave (
        input  we, re, addr, wdata, out_ready, in_valid, in_data,
        output rdata, out_valid, out_data, in_ready, irq
    );
endinterface

// File: rtl/io_responder_fifo.sv
// io_fifo: DEPTH-entry TX FIFO with head-of-queue read port and occupancy count.
// DEPTH must be a power of two so the pointers wrap naturally.
module io_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_wdata,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_head,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_head  = r_mem[r_rptr];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    // Storage is not reset: a reset only has to forget the contents via the pointers.
    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wptr] <= i_wdata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push)
                r_wptr <= r_wptr + AW'(1);
            if (w_pop)
                r_rptr <= r_rptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: rtl/io_responder.sv
// io_responder: CPU register block with a TX FIFO toward a device and a single RX
// holding register. Optional interrupt logic is enabled by defining IO_RESPONDER_IRQ_EN.
module io_responder
    import io_responder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input logic           clk,
    input logic           reset,
    io_responder_if.slave bus
);
    localparam int CW = $clog2(DEPTH) + 1;

    addr_e            w_addr;
    logic             w_tx_store;
    logic             w_full;
    logic             w_empty;
    logic [CW-1:0]    w_count;
    logic [WIDTH-1:0] w_head;
    logic             w_rx_cap;
    logic             w_rx_pop;
    logic [ST_W-1:0]  w_status;
    logic [WIDTH-1:0] w_mask_rd;
    logic [WIDTH-1:0] w_rdata;

    logic             r_tx_ovf;
    logic             r_rx_full;
    logic [WIDTH-1:0] r_rx_data;

    assign w_addr     = addr_e'(bus.addr);
    assign w_tx_store = bus.we && (w_addr == ADDR_TXDATA);
    assign w_rx_cap   = bus.in_valid && !r_rx_full;
    assign w_rx_pop   = bus.re && (w_addr == ADDR_RXDATA) && r_rx_full;

    io_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_tx_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_tx_store && !w_full),
        .i_wdata (bus.wdata),
        .i_pop   (bus.out_ready && !w_empty),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign bus.out_valid = !w_empty;
    assign bus.out_data  = w_head;
    assign bus.in_ready  = !r_rx_full;

    // Overflow looks at fullness before the edge, so a same-cycle device pop does not rescue the word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_tx_ovf <= 1'b0;
        else if (w_tx_store && w_full)
            r_tx_ovf <= 1'b1;
        else if (bus.we && (w_addr == ADDR_STATUS) && bus.wdata[ST_TX_OVF])
            r_tx_ovf <= 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_rx_full <= 1'b0;
        else if (w_rx_cap)
            r_rx_full <= 1'b1;
        else if (w_rx_pop)
            r_rx_full <= 1'b0;
    end

    always_ff @(posedge clk) begin
        if (w_rx_cap)
            r_rx_data <= bus.in_data;
    end

    assign w_status = pack_status(w_empty, w_full, r_rx_full, r_tx_ovf, ST_COUNT_W'(w_count));

`ifdef IO_RESPONDER_IRQ_EN
    logic [2:0] r_irq_mask;
    logic       r_irq;

    // Mask bit order: [0] tx_empty, [1] rx_full, [2] tx_ovf.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_irq_mask <= 3'b000;
            r_irq      <= 1'b0;
        end else begin
            if (bus.we && (w_addr == ADDR_IRQMASK))
                r_irq_mask <= bus.wdata[2:0];
            r_irq <= |(r_irq_mask & {r_tx_ovf, r_rx_full, w_empty});
        end
    end

    assign w_mask_rd = WIDTH'(r_irq_mask);
    assign bus.irq   = r_irq;
`else
    assign w_mask_rd = '0;
    assign bus.irq   = 1'b0;
`endif

    always_comb begin
        w_rdata = '0;
        case (w_addr)
            ADDR_RXDATA:  w_rdata = r_rx_full ? r_rx_data : '0;
            ADDR_STATUS:  w_rdata = WIDTH'(w_status);
            ADDR_IRQMASK: w_rdata = w_mask_rd;
            default:      w_rdata = '0;
        endcase
    end

    assign bus.rdata = w_rdata;
endmodule

// File: tb/tb_io_responder.sv
// Bench for io_responder: table of register-bus cycles with a TX scoreboard,
// plus hand-written sequences for interrupt latency and asynchronous reset.
module tb_io_responder;
    localparam int WIDTH = 16;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset;

    io_responder_if #(.WIDTH(WIDTH)) bus ();

    io_responder #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic        re;
        logic [1:0]  addr;
        logic [15:0] wdata;
        logic        ordy;
        logic        ivld;
        logic [15:0] idata;
        logic        chk;
        logic [15:0] exp_rd;
        logic        exp_inr;
    } vec_t;

    vec_t        vecs[$];
    logic [15:0] exp_q[$];
    int          n_pass  = 0;
    int          n_total = 0;

    function automatic vec_t v(input logic we, input logic re, input logic [1:0] addr,
                               input logic [15:0] wdata, input logic ordy, input logic ivld,
                               input logic [15:0] idata, input logic chk,
                               input logic [15:0] exp_rd, input logic exp_inr);
        vec_t r;
        r.we = we; r.re = re; r.addr = addr; r.wdata = wdata; r.ordy = ordy;
        r.ivld = ivld; r.idata = idata; r.chk = chk; r.exp_rd = exp_rd; r.exp_inr = exp_inr;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic drive(input logic we, input logic re, input logic [1:0] addr,
                         input logic [15:0] wdata, input logic ordy, input logic ivld,
                         input logic [15:0] idata);
        bus.we        = we;
        bus.re        = re;
        bus.addr      = addr;
        bus.wdata     = wdata;
        bus.out_ready = ordy;
        bus.in_valid  = ivld;
        bus.in_data   = idata;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 2'd0, 16'h0000, 1'b0, 1'b0, 16'h0000);
    endtask

    // Called between edges: fullness is judged before this cycle's pop.
    task automatic sb_tick();
        bit          full_m;
        logic [15:0] e;
        full_m = (exp_q.size() == DEPTH);
        check("out_valid", bus.out_valid, exp_q.size() != 0);
        if (bus.out_valid && bus.out_ready && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("tx_data", bus.out_data, e);
        end
        if (bus.we && bus.addr == 2'd0 && !full_m)
            exp_q.push_back(bus.wdata);
    endtask

    task automatic cycle();
        @(negedge clk);
        sb_tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Basic TX path: two words queued then drained in order.
        vecs.push_back(v(0,1,2,16'h0000,0,0,16'h0000,1,16'h0001,1));
        vecs.push_back(v(1,0,0,16'h1234,0,0,16'h0000,1,16'h0000,1));
        vecs.push_back(v(1,0,0,16'h5678,0,0,16'h0000,1,16'h0000,1));
        vecs.push_back(v(0,1,2,16'h0000,0,0,16'h0000,1,16'h0020,1));
        vecs.push_back(v(0,0,2,16'h0000,1,0,16'h0000,1,16'h0020,1));
        vecs.push_back(v(0,0,2,16'h0000,1,0,16'h0000,1,16'h0010,1));
        vecs.push_back(v(0,0,2,16'h0000,0,0,16'h0000,1,16'h0001,1));
        // Push and pop in the same cycle keep the count.
        vecs.push_back(v(1,0,0,16'h2222,0,0,16'h0000,0,16'h0000,1));
        vecs.push_back(v(1,0,0,16'h3333,1,0,16'h0000,1,16'h0000,1));
        vecs.push_back(v(0,0,2,16'h0000,0,0,16'h0000,1,16'h0010,1));
        vecs.push_back(v(0,0,2,16'h0000,1,0,16'h0000,1,16'h0010,1));
        vecs.push_back(v(0,0,2,16'h0000,0,0,16'h0000,1,16'h0001,1));
        // Overflow: fifth store dropped, then cleared via STATUS.
        vecs.push_back(v(1,0,0,16'hA001,0,0,16'h0000,1,16'h0000,1));
        vecs.push_back(v(1,0,0,16'hA002,0,0,16'h0000,1,16'h0000,1));
        vecs.push_back(v(1,0,0,16'hA003,0,0,16'h0000,1,16'h0000,1));
        vecs.push_back(v(1,0,0,16'hA004,0,0,16'h0000,1,16'h0000,1));
        vecs.push_back(v(1,0,0,16'hA005,0,0,16'h0000,1,16'h0000,1));
        vecs.push_back(v(0,1,2,16'h0000,0,0,16'h0000,1,16'h004A,1));
        vecs.push_back(v(1,1,2,16'h0008,0,0,16'h0000,1,16'h004A,1));
        vecs.push_back(v(0,0,2,16'h0000,0,0,16'h0000,1,16'h0042,1));
        // Store while full with a simultaneous device pop still overflows.
        vecs.push_back(v(1,0,0,16'hB005,1,0,16'h0000,1,16'h0000,1));
        vecs.push_back(v(0,0,2,16'h0000,0,0,16'h0000,1,16'h0038,1));
        vecs.push_back(v(1,0,2,16'hFFF7,0,0,16'h0000,1,16'h0038,1));
        vecs.push_back(v(0,0,2,16'h0000,0,0,16'h0000,1,16'h0038,1));
        vecs.push_back(v(1,0,2,16'h0008,0,0,16'h0000,1,16'h0038,1));
        vecs.push_back(v(0,0,2,16'h0000,1,0,16'h0000,1,16'h0030,1));
        vecs.push_back(v(0,0,2,16'h0000,1,0,16'h0000,1,16'h0020,1));
        vecs.push_back(v(0,0,2,16'h0000,1,0,16'h0000,1,16'h0010,1));
        vecs.push_back(v(0,0,2,16'h0000,0,0,16'h0000,1,16'h0001,1));
        // RX holding register: capture, hold-off, pop, recapture.
        vecs.push_back(v(0,1,1,16'h0000,0,1,16'hBEEF,1,16'h0000,1));
        vecs.push_back(v(0,0,2,16'h0000,0,1,16'hCAFE,1,16'h0005,0));
        vecs.push_back(v(0,1,1,16'h0000,0,1,16'hCAFE,1,16'hBEEF,0));
        vecs.push_back(v(0,0,1,16'h0000,0,0,16'h0000,1,16'h0000,1));
        vecs.push_back(v(0,0,1,16'h0000,0,1,16'hCAFE,1,16'h0000,1));
        vecs.push_back(v(1,1,1,16'h1111,0,0,16'h0000,1,16'hCAFE,0));
        vecs.push_back(v(0,0,1,16'h0000,0,0,16'h0000,1,16'h0000,1));
        // Loads of TXDATA return 0 and never pop.
        vecs.push_back(v(1,0,0,16'h4444,0,0,16'h0000,1,16'h0000,1));
        vecs.push_back(v(0,1,0,16'h0000,0,0,16'h0000,1,16'h0000,1));
        vecs.push_back(v(0,0,2,16'h0000,0,0,16'h0000,1,16'h0010,1));
        vecs.push_back(v(0,0,2,16'h0000,1,0,16'h0000,1,16'h0010,1));
        vecs.push_back(v(0,0,2,16'h0000,0,0,16'h0000,1,16'h0001,1));
        // IRQMASK register.
        vecs.push_back(v(1,0,3,16'hFFFF,0,0,16'h0000,1,16'h0000,1));
`ifdef IO_RESPONDER_IRQ_EN
        vecs.push_back(v(0,1,3,16'h0000,0,0,16'h0000,1,16'h0007,1));
        vecs.push_back(v(1,0,3,16'h0000,0,0,16'h0000,1,16'h0007,1));
        vecs.push_back(v(0,0,3,16'h0000,0,0,16'h0000,1,16'h0000,1));
`else
        vecs.push_back(v(0,1,3,16'h0000,0,0,16'h0000,1,16'h0000,1));
`endif

        idle();
        reset = 1'b1;
        #12;
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_in_ready", bus.in_ready, 1'b1);
        check("rst_irq", bus.irq, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i].we, vecs[i].re, vecs[i].addr, vecs[i].wdata,
                  vecs[i].ordy, vecs[i].ivld, vecs[i].idata);
            @(negedge clk);
            if (vecs[i].chk)
                check($sformatf("rdata[%0d]", i), bus.rdata, vecs[i].exp_rd);
            check($sformatf("in_ready[%0d]", i), bus.in_ready, vecs[i].exp_inr);
            sb_tick();
            @(posedge clk);
            #1;
        end

        idle();
        cycle();
        cycle();
        check("irq_idle", bus.irq, 1'b0);
`ifdef IO_RESPONDER_IRQ_EN
        drive(1'b1, 1'b0, 2'd3, 16'h0002, 1'b0, 1'b0, 16'h0000);
        cycle();
        idle();
        cycle();
        check("irq_masked_quiet", bus.irq, 1'b0);
        drive(1'b0, 1'b0, 2'd0, 16'h0000, 1'b0, 1'b1, 16'hBEEF);
        cycle();
        check("irq_rx_lat0", bus.irq, 1'b0);
        idle();
        cycle();
        check("irq_rx_set", bus.irq, 1'b1);
        drive(1'b0, 1'b1, 2'd1, 16'h0000, 1'b0, 1'b0, 16'h0000);
        cycle();
        check("irq_pop_lat0", bus.irq, 1'b1);
        idle();
        cycle();
        check("irq_pop_clr", bus.irq, 1'b0);
        drive(1'b1, 1'b0, 2'd3, 16'h0000, 1'b0, 1'b0, 16'h0000);
        cycle();
        idle();
`else
        drive(1'b0, 1'b0, 2'd0, 16'h0000, 1'b0, 1'b1, 16'hBEEF);
        cycle();
        idle();
        cycle();
        cycle();
        check("irq_tied_low", bus.irq, 1'b0);
        drive(1'b0, 1'b1, 2'd1, 16'h0000, 1'b0, 1'b0, 16'h0000);
        cycle();
        idle();
`endif

        // Asynchronous reset with three words queued and RX full.
        drive(1'b1, 1'b0, 2'd0, 16'hC001, 1'b0, 1'b1, 16'h5A5A);
        cycle();
        drive(1'b1, 1'b0, 2'd0, 16'hC002, 1'b0, 1'b0, 16'h0000);
        cycle();
        drive(1'b1, 1'b0, 2'd0, 16'hC003, 1'b0, 1'b0, 16'h0000);
        cycle();
        drive(1'b0, 1'b1, 2'd2, 16'h0000, 1'b0, 1'b0, 16'h0000);
        @(negedge clk);
        check("pre_rst_status", bus.rdata, 16'h0034);
        check("pre_rst_out_valid", bus.out_valid, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_out_valid", bus.out_valid, 1'b0);
        check("async_rst_in_ready", bus.in_ready, 1'b1);
        check("async_rst_status", bus.rdata, 16'h0001);
        exp_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_status", bus.rdata, 16'h0001);
        check("post_rst_irq", bus.irq, 1'b0);
        drive(1'b0, 1'b1, 2'd1, 16'h0000, 1'b0, 1'b0, 16'h0000);
        @(negedge clk);
        check("post_rst_rxdata", bus.rdata, 16'h0000);
        sb_tick();
        @(posedge clk);
        #1;
        idle();
        cycle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
